// File: rtl/hl_pkg.sv
// Shared definitions for the high-speed to low-speed bus adapter:
// FSM encoding, operation encoding and default widths.
package hl_pkg;

    localparam int DW_DEF  = 32;
    localparam int AW_DEF  = 32;
    localparam int BSW_DEF = 4;
    localparam int TMO_DEF = 255;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // A channel raising both enables is treated as a write.
    function automatic op_t op_sel(input logic wr_en);
        return wr_en ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last+1 (mod N) and returns a one-hot grant.
module rr_arbiter #(
    parameter int N = 2,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant
);

    int            pos;
    logic [LW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            idx = pos[LW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hl_adapter_mc.sv
// Multi-channel adapter: arbitrates high-side requests onto a single slow
// low-side bus paced by an asynchronous strobe, with per-transaction timeout.
module hl_adapter_mc
    import hl_pkg::*;
#(
    parameter int NCH = 2,
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int BSW = BSW_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     h_read_en,
    input  logic [NCH-1:0]     h_write_en,
    input  logic [NCH*AW-1:0]  h_addr,
    input  logic [NCH*DW-1:0]  h_wdata,
    input  logic [NCH*BSW-1:0] h_byte_size,
    output logic [NCH-1:0]     h_ready,
    output logic [NCH-1:0]     h_err,
    output logic [DW-1:0]      h_rdata,
    input  logic               l_clk,
    input  logic               l_ready,
    input  logic [DW-1:0]      l_rdata,
    output logic               l_read_en,
    output logic               l_write_en,
    output logic [AW-1:0]      l_addr,
    output logic [DW-1:0]      l_wdata,
    output logic [BSW-1:0]     l_byte_size
);

    localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [LW-1:0]    last_q, last_d, gnt_q, gnt_d, arb_idx;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
    logic [BSW-1:0]   bsz_q, bsz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d, drop_q, drop_d;
    logic             sync1_q, sync2_q, sync3_q, tick_q;
    logic [NCH-1:0]   req, arb_gnt;
    logic             gnt_req, busy;

    assign req     = h_read_en | h_write_en;
    assign gnt_req = req[gnt_q];

    rr_arbiter #(.N(NCH)) u_arb (
        .req   (req),
        .last  (last_q),
        .grant (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (arb_gnt[i]) arb_idx = LW'(i);
        end
    end

    // drop_q remembers an early release so RESP lasts a single cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bsz_d   = bsz_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        drop_d  = drop_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (|req) begin
                    gnt_d   = arb_idx;
                    last_d  = arb_idx;
                    addr_d  = h_addr[int'(arb_idx)*AW +: AW];
                    wdata_d = h_wdata[int'(arb_idx)*DW +: DW];
                    bsz_d   = h_byte_size[int'(arb_idx)*BSW +: BSW];
                    op_d    = op_sel(h_write_en[arb_idx]);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!gnt_req) drop_d = 1'b1;
                if (tick_q) begin
                    cnt_d   = CNT_W'(TMO);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!gnt_req) drop_d = 1'b1;
                if (tick_q) begin
                    if (l_ready) begin
                        err_d   = 1'b0;
                        if (op_q == OP_READ) rdata_d = l_rdata;
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            err_d   = 1'b1;
                            if (op_q == OP_READ) rdata_d = '0;
                            state_d = S_RESP;
                        end
                    end
                end
            end
            S_RESP: begin
                if (drop_q || !gnt_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            last_q  <= LW'(NCH - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            bsz_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            rdata_q <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bsz_q   <= bsz_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            sync1_q <= l_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            tick_q  <= sync2_q & ~sync3_q;
        end
    end

    always_comb begin
        h_ready = '0;
        h_err   = '0;
        if (state_q == S_RESP) begin
            h_ready[gnt_q] = 1'b1;
            h_err[gnt_q]   = err_q;
        end
    end

    assign busy        = (state_q == S_SETUP) || (state_q == S_WAIT);
    assign l_read_en   = busy && (op_q == OP_READ);
    assign l_write_en  = busy && (op_q == OP_WRITE);
    assign l_addr      = addr_q;
    assign l_wdata     = wdata_q;
    assign l_byte_size = bsz_q;
    assign h_rdata     = rdata_q;

endmodule

// File: tb/tb_hl_adapter_mc.sv
// Directed bench for hl_adapter_mc with two channels and a short timeout.
module tb_hl_adapter_mc;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BSW = 4;
    localparam int TMO = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NCH-1:0]     h_read_en = '0;
    logic [NCH-1:0]     h_write_en = '0;
    logic [NCH*AW-1:0]  h_addr = '0;
    logic [NCH*DW-1:0]  h_wdata = '0;
    logic [NCH*BSW-1:0] h_byte_size = '0;
    logic [NCH-1:0]     h_ready;
    logic [NCH-1:0]     h_err;
    logic [DW-1:0]      h_rdata;
    logic               l_clk = 1'b0;
    logic               l_ready = 1'b0;
    logic [DW-1:0]      l_rdata = '0;
    logic               l_read_en;
    logic               l_write_en;
    logic [AW-1:0]      l_addr;
    logic [DW-1:0]      l_wdata;
    logic [BSW-1:0]     l_byte_size;

    int passed = 0;
    int checks = 0;
    int hr_rise [NCH] = '{default: 0};
    int hr_cyc  [NCH] = '{default: 0};
    logic [NCH-1:0] hr_prev = '0;

    hl_adapter_mc #(.NCH(NCH), .DW(DW), .AW(AW), .BSW(BSW), .TMO(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .h_read_en   (h_read_en),
        .h_write_en  (h_write_en),
        .h_addr      (h_addr),
        .h_wdata     (h_wdata),
        .h_byte_size (h_byte_size),
        .h_ready     (h_ready),
        .h_err       (h_err),
        .h_rdata     (h_rdata),
        .l_clk       (l_clk),
        .l_ready     (l_ready),
        .l_rdata     (l_rdata),
        .l_read_en   (l_read_en),
        .l_write_en  (l_write_en),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_byte_size (l_byte_size)
    );

    always #5 clk = ~clk;

    // Count h_ready pulses and high cycles per channel.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (h_ready[c]) hr_cyc[c]++;
            if (h_ready[c] && !hr_prev[c]) hr_rise[c]++;
        end
        hr_prev = h_ready;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full low-side strobe period; the resulting tick lands well inside it.
    task automatic lpulse();
        l_clk = 1'b1;
        repeat (4) step();
        l_clk = 1'b0;
        repeat (4) step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        h_read_en = '0;
        h_write_en = '0;
        l_clk = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (h_ready !== 2'b00) $display("FAIL rst_ready: got %b want 00", h_ready); else passed++;
        checks++; if (h_err !== 2'b00) $display("FAIL rst_err: got %b want 00", h_err); else passed++;
        checks++; if (h_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", h_rdata); else passed++;
        checks++; if ({l_read_en, l_write_en} !== 2'b00) $display("FAIL rst_lcmd: got %b want 00", {l_read_en, l_write_en}); else passed++;
        checks++; if (l_addr !== 32'h0) $display("FAIL rst_laddr: got %h want 0", l_addr); else passed++;
        checks++; if (l_wdata !== 32'h0) $display("FAIL rst_lwdata: got %h want 0", l_wdata); else passed++;
        checks++; if (l_byte_size !== 4'h0) $display("FAIL rst_lbsz: got %h want 0", l_byte_size); else passed++;
    endtask

    task automatic test_single_read();
        h_addr[0 +: AW] = 32'h0000_0100;
        h_byte_size[0 +: BSW] = 4'd4;
        l_ready = 1'b1;
        l_rdata = 32'hDEAD_BEEF;
        h_read_en = 2'b01;
        step();
        @(negedge clk);
        checks++; if ({l_read_en, l_write_en} !== 2'b10) $display("FAIL rd_setup_cmd: got %b want 10", {l_read_en, l_write_en}); else passed++;
        checks++; if (l_addr !== 32'h0000_0100) $display("FAIL rd_laddr: got %h want 00000100", l_addr); else passed++;
        checks++; if (l_byte_size !== 4'd4) $display("FAIL rd_lbsz: got %h want 4", l_byte_size); else passed++;
        lpulse();
        @(negedge clk);
        checks++; if (l_read_en !== 1'b1) $display("FAIL rd_wait_cmd: got %b want 1", l_read_en); else passed++;
        checks++; if (h_ready !== 2'b00) $display("FAIL rd_early_ready: got %b want 00", h_ready); else passed++;
        lpulse();
        @(negedge clk);
        checks++; if (h_ready !== 2'b01) $display("FAIL rd_ready: got %b want 01", h_ready); else passed++;
        checks++; if (h_err !== 2'b00) $display("FAIL rd_err: got %b want 00", h_err); else passed++;
        checks++; if (h_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h want deadbeef", h_rdata); else passed++;
        checks++; if (l_read_en !== 1'b0) $display("FAIL rd_resp_cmd: got %b want 0", l_read_en); else passed++;
        h_read_en = 2'b00;
        step();
        @(negedge clk);
        checks++; if (h_ready !== 2'b00) $display("FAIL rd_release: got %b want 00", h_ready); else passed++;
    endtask

    task automatic test_rw_both();
        h_addr[AW +: AW] = 32'h0000_0400;
        h_wdata[DW +: DW] = 32'h0BAD_CAFE;
        l_ready = 1'b1;
        l_rdata = 32'h1111_2222;
        h_read_en = 2'b10;
        h_write_en = 2'b10;
        step();
        @(negedge clk);
        checks++; if ({l_read_en, l_write_en} !== 2'b01) $display("FAIL rw_cmd: got %b want 01", {l_read_en, l_write_en}); else passed++;
        checks++; if (l_wdata !== 32'h0BAD_CAFE) $display("FAIL rw_lwdata: got %h want 0badcafe", l_wdata); else passed++;
        checks++; if (l_addr !== 32'h0000_0400) $display("FAIL rw_laddr: got %h want 00000400", l_addr); else passed++;
        lpulse();
        lpulse();
        @(negedge clk);
        checks++; if (h_ready !== 2'b10) $display("FAIL rw_ready: got %b want 10", h_ready); else passed++;
        checks++; if (h_rdata !== 32'hDEAD_BEEF) $display("FAIL rw_rdata_kept: got %h want deadbeef", h_rdata); else passed++;
        h_read_en = 2'b00;
        h_write_en = 2'b00;
        step();
    endtask

    task automatic test_round_robin();
        logic [31:0]    exp_wd, exp_ad;
        logic [NCH-1:0] exp_rdy;
        apply_reset();
        l_ready = 1'b1;
        h_addr[0 +: AW] = 32'h0000_0200;
        h_addr[AW +: AW] = 32'h0000_0300;
        for (int n = 0; n < 6; n++) begin
            h_wdata[0 +: DW] = 32'hA0A0_0000 | n;
            h_wdata[DW +: DW] = 32'hB1B1_0000 | n;
            exp_wd = (n % 2 == 1) ? (32'hB1B1_0000 | n) : (32'hA0A0_0000 | n);
            exp_ad = (n % 2 == 1) ? 32'h0000_0300 : 32'h0000_0200;
            exp_rdy = (n % 2 == 1) ? 2'b10 : 2'b01;
            h_write_en = 2'b11;
            step();
            @(negedge clk);
            checks++; if (l_wdata !== exp_wd) $display("FAIL rr_wdata[%0d]: got %h want %h", n, l_wdata, exp_wd); else passed++;
            checks++; if (l_addr !== exp_ad) $display("FAIL rr_addr[%0d]: got %h want %h", n, l_addr, exp_ad); else passed++;
            lpulse();
            lpulse();
            @(negedge clk);
            checks++; if (h_ready !== exp_rdy) $display("FAIL rr_ready[%0d]: got %b want %b", n, h_ready, exp_rdy); else passed++;
            h_write_en = 2'b00;
            step();
        end
        @(negedge clk);
        checks++; if (h_rdata !== 32'h0) $display("FAIL rr_rdata_kept: got %h want 0", h_rdata); else passed++;
    endtask

    task automatic test_timeout();
        l_ready = 1'b1;
        l_rdata = 32'h1234_5678;
        h_read_en = 2'b01;
        step();
        lpulse();
        lpulse();
        @(negedge clk);
        checks++; if (h_rdata !== 32'h1234_5678) $display("FAIL to_pre_rdata: got %h want 12345678", h_rdata); else passed++;
        h_read_en = 2'b00;
        step();
        l_ready = 1'b0;
        l_rdata = 32'hFFFF_FFFF;
        h_read_en = 2'b01;
        step();
        for (int t = 1; t <= 4; t++) begin
            lpulse();
            @(negedge clk);
            checks++; if (h_ready !== 2'b00) $display("FAIL to_early[%0d]: got %b want 00", t, h_ready); else passed++;
        end
        checks++; if (l_read_en !== 1'b1) $display("FAIL to_cmd_held: got %b want 1", l_read_en); else passed++;
        lpulse();
        @(negedge clk);
        checks++; if (h_ready !== 2'b01) $display("FAIL to_ready: got %b want 01", h_ready); else passed++;
        checks++; if (h_err !== 2'b01) $display("FAIL to_err: got %b want 01", h_err); else passed++;
        checks++; if (h_rdata !== 32'h0) $display("FAIL to_rdata: got %h want 0", h_rdata); else passed++;
        h_read_en = 2'b00;
        step();
        @(negedge clk);
        checks++; if (h_err !== 2'b00) $display("FAIL to_err_clear: got %b want 00", h_err); else passed++;
        l_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int snap;
        snap = hr_rise[0];
        l_ready = 1'b1;
        l_rdata = 32'h7777_7777;
        h_addr[0 +: AW] = 32'h0000_0500;
        h_read_en = 2'b01;
        step();
        lpulse();
        @(negedge clk);
        checks++; if (l_read_en !== 1'b1) $display("FAIL rm_wait_cmd: got %b want 1", l_read_en); else passed++;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (l_read_en !== 1'b0) $display("FAIL rm_cmd: got %b want 0", l_read_en); else passed++;
        checks++; if (h_ready !== 2'b00) $display("FAIL rm_ready: got %b want 00", h_ready); else passed++;
        checks++; if (h_rdata !== 32'h0) $display("FAIL rm_rdata: got %h want 0", h_rdata); else passed++;
        h_read_en = 2'b00;
        lpulse();
        step();
        checks++; if (hr_rise[0] !== snap) $display("FAIL rm_no_pulse: got %0d want %0d", hr_rise[0], snap); else passed++;
        h_addr[AW +: AW] = 32'h0000_0600;
        l_rdata = 32'hCAFE_F00D;
        h_read_en = 2'b10;
        step();
        @(negedge clk);
        checks++; if (l_addr !== 32'h0000_0600) $display("FAIL rm_ch1_addr: got %h want 00000600", l_addr); else passed++;
        lpulse();
        lpulse();
        @(negedge clk);
        checks++; if (h_ready !== 2'b10) $display("FAIL rm_ch1_ready: got %b want 10", h_ready); else passed++;
        checks++; if (h_rdata !== 32'hCAFE_F00D) $display("FAIL rm_ch1_rdata: got %h want cafef00d", h_rdata); else passed++;
        h_read_en = 2'b00;
        step();
    endtask

    task automatic test_early_drop();
        int snap_r, snap_c;
        snap_r = hr_rise[0];
        snap_c = hr_cyc[0];
        l_ready = 1'b1;
        l_rdata = 32'h55AA_55AA;
        h_read_en = 2'b01;
        step();
        lpulse();
        h_read_en = 2'b00;
        lpulse();
        repeat (4) step();
        checks++; if (hr_rise[0] - snap_r !== 1) $display("FAIL drop_pulses: got %0d want 1", hr_rise[0] - snap_r); else passed++;
        checks++; if (hr_cyc[0] - snap_c !== 1) $display("FAIL drop_resp_len: got %0d want 1", hr_cyc[0] - snap_c); else passed++;
        @(negedge clk);
        checks++; if (h_rdata !== 32'h55AA_55AA) $display("FAIL drop_rdata: got %h want 55aa55aa", h_rdata); else passed++;
        checks++; if (h_ready !== 2'b00) $display("FAIL drop_ready_low: got %b want 00", h_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rw_both();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_early_drop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
